// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline front-end hazard controller:
//   state_e      - controller states (RUN: fetch may proceed, WAIT: memory busy)
//   REG_ZERO     - architectural zero register, never a real dependency
//   MEM_LAT_MAX  - largest instruction-memory latency the 4-bit wait counter holds
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         MEM_LAT_MAX = 15;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset (clears the count)
//   i_inc   in   count this cycle
//   o_count out  WIDTH-bit saturating count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: clocked state is written only with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Front-end controller for the IF stage and IF/ID register. Each cycle it
// decides whether the PC advances, whether IF/ID loads, whether the fetched
// instruction is squashed and which next-PC source is used. A multi-cycle
// instruction memory is covered by WAIT cycles after every PC write.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   id_rs, id_rt        source fields of the instruction in ID
//   id_uses_rt          ID instruction reads rt
//   ex_mem_read, ex_rt  load in EX and its destination register
//   id_branch_taken     branch in ID resolved taken
//   id_jmp              jump in ID
//   pc_write            PC load enable
//   ifid_write          IF/ID load enable
//   flush               squash the instruction entering IF/ID
//   pc_src              select branch target
//   jmp                 select jump target (wins over pc_src)
//   id_bubble           zero ID control into ID/EX
//   stall_cnt           saturating count of cycles with pc_write=0
//   flush_cnt           saturating count of cycles with flush=1
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             id_branch_taken,
    input  logic             id_jmp,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             flush,
    output logic             pc_src,
    output logic             jmp,
    output logic             id_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    if (MEM_LAT < 0 || MEM_LAT > MEM_LAT_MAX) begin : g_lat_range
        $error("hazard_ctrl: MEM_LAT out of range 0..15");
    end

    localparam logic [3:0] LAT         = 4'(MEM_LAT);
    localparam state_e     RESET_STATE = (MEM_LAT > 0) ? WAIT : RUN;

    state_e     r_state;
    logic [3:0] r_wait_cnt;

    logic w_load_use;
    logic w_redirect;

    // A load writing r0 never creates a dependency; rt only matters when read.
    assign w_load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign w_redirect = id_jmp || id_branch_taken;

    // NOTE: every output gets its safe (stall) value first, so each path through
    // the block assigns all of them and no latch is inferred.
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        id_bubble  = 1'b1;
        flush      = 1'b0;
        pc_src     = 1'b0;
        jmp        = 1'b0;
        // Reset, memory wait and load-use all hold the front end with a bubble.
        if (!rst && (r_state == RUN) && !w_load_use) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            id_bubble  = 1'b0;
            if (w_redirect) begin
                flush  = 1'b1;
                jmp    = id_jmp;
                pc_src = id_branch_taken && !id_jmp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RESET_STATE;
            r_wait_cnt <= LAT;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
            if (r_wait_cnt == 4'd1) begin
                r_state <= RUN;
            end
        end else if (pc_write && (MEM_LAT > 0)) begin
            // Every new PC starts a fresh memory access of MEM_LAT extra cycles.
            r_wait_cnt <= LAT;
            r_state    <= WAIT;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (!pc_write),
        .o_count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (flush),
        .o_count (flush_cnt)
    );

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Two controllers share one stimulus stream: a single-cycle-memory instance
// with 32-bit counters and a MEM_LAT=3 instance with 4-bit counters (so the
// statistics reach saturation quickly). A driver applies inputs just after
// each rising edge and pushes the reference model's expected response into
// a queue per instance; a monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    typedef struct {
        logic [5:0] ctl;   // {pc_write, ifid_write, flush, pc_src, jmp, id_bubble}
        longint     sc;
        longint     fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0;
    logic       id_branch_taken = 1'b0, id_jmp = 1'b0;

    logic        a_pcw, a_ifw, a_fl, a_ps, a_jp, a_bub;
    logic [31:0] a_sc, a_fc;
    logic        b_pcw, b_ifw, b_fl, b_ps, b_jp, b_bub;
    logic [3:0]  b_sc, b_fc;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t   q0[$];
    exp_t   q3[$];
    int     wl[2] = '{0, 0};
    longint sc[2] = '{0, 0};
    longint fc[2] = '{0, 0};

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_LAT(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
        .id_jmp(id_jmp), .pc_write(a_pcw), .ifid_write(a_ifw), .flush(a_fl),
        .pc_src(a_ps), .jmp(a_jp), .id_bubble(a_bub), .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    hazard_ctrl #(.MEM_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_branch_taken(id_branch_taken),
        .id_jmp(id_jmp), .pc_write(b_pcw), .ifid_write(b_ifw), .flush(b_fl),
        .pc_src(b_ps), .jmp(b_jp), .id_bubble(b_bub), .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: wl[k] counts memory-busy cycles still owed before the
    // next fetch may happen; counters are plain integers clipped at their max.
    task automatic model(input int k, output exp_t e);
        int     lat;
        longint mx;
        logic   pcw, ifw, fl, ps, jp, bub, hazard;
        lat = (k == 0) ? 0 : 3;
        mx  = (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd15;
        pcw = 0; ifw = 0; fl = 0; ps = 0; jp = 0; bub = 1;
        hazard = ex_mem_read && (ex_rt != 0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        if (rst) begin
            wl[k] = lat;
            sc[k] = 0;
            fc[k] = 0;
        end else if (wl[k] > 0) begin
            wl[k]--;
        end else if (!hazard) begin
            pcw = 1; ifw = 1; bub = 0;
            if (id_jmp || id_branch_taken) begin
                fl = 1;
                jp = id_jmp;
                ps = id_branch_taken && !id_jmp;
            end
            wl[k] = lat;
        end
        e.ctl = {pcw, ifw, fl, ps, jp, bub};
        e.sc  = sc[k];
        e.fc  = fc[k];
        if (!rst) begin
            if (!pcw && sc[k] < mx) sc[k]++;
            if (fl && fc[k] < mx) fc[k]++;
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ur, input logic mr, input logic [4:0] ert,
                         input logic br, input logic j);
        exp_t e0, e3;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; id_uses_rt = ur;
        ex_mem_read = mr; ex_rt = ert; id_branch_taken = br; id_jmp = j;
        model(0, e0);
        q0.push_back(e0);
        model(1, e3);
        q3.push_back(e3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0);
    endtask

    // Monitor: compares whatever the driver has queued, one entry per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("lat0 ctl{pcw,ifw,fl,ps,jmp,bub}",
                      longint'({a_pcw, a_ifw, a_fl, a_ps, a_jp, a_bub}), longint'(e.ctl));
                check("lat0 stall_cnt", longint'(a_sc), e.sc);
                check("lat0 flush_cnt", longint'(a_fc), e.fc);
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check("lat3 ctl{pcw,ifw,fl,ps,jmp,bub}",
                      longint'({b_pcw, b_ifw, b_fl, b_ps, b_jp, b_bub}), longint'(e.ctl));
                check("lat3 stall_cnt", longint'(b_sc), e.sc);
                check("lat3 flush_cnt", longint'(b_fc), e.fc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within 1 ms");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, then quiet running.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        // Load-use on rs, then the same with the load writing r0.
        drive(0, 5'd8, 5'd3, 0, 1, 5'd8, 0, 0);
        idle(4);
        drive(0, 5'd0, 5'd3, 0, 1, 5'd0, 0, 0);
        idle(4);
        // rt match only counts when rt is a source.
        drive(0, 5'd4, 5'd9, 0, 1, 5'd9, 0, 0);
        idle(4);
        drive(0, 5'd4, 5'd9, 1, 1, 5'd9, 0, 0);
        idle(4);
        // Branch and jump together: jump wins.
        drive(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1);
        idle(4);
        // Load-use with a taken branch: stall first, redirect next cycle.
        drive(0, 5'd6, 5'd2, 0, 1, 5'd6, 1, 0);
        drive(0, 5'd6, 5'd2, 0, 0, 5'd0, 1, 0);
        idle(4);
        // Redirects held over several cycles land in WAIT on the slow instance.
        for (int i = 0; i < 6; i++) drive(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0);
        // Reset pulse in the middle of a wait, then a redirect in the wait.
        drive(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1);
        drive(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0);
        drive(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0);
        drive(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1);
        idle(8);
        // Randomised traffic with small register indices to provoke matches.
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 79) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end
        repeat (2) @(negedge clk);
        check("lat0 scoreboard drained", longint'(q0.size()), 0);
        check("lat3 scoreboard drained", longint'(q3.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_hazard_ctrl
